// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, constants and helpers for the 4x4 keypad
//               scanner (FSM states, per-scan result kinds, matrix geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  // Column drive right after reset: column 0 selected.
  localparam logic [3:0] COL_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } result_t;

  // Number of asserted bits in a 4-bit active-high row vector.
  function automatic logic [2:0] count_active(input logic [3:0] act);
    count_active = 3'(act[0]) + 3'(act[1]) + 3'(act[2]) + 3'(act[3]);
  endfunction

  // Index of the lowest asserted row (only meaningful for a one-hot input).
  function automatic logic [1:0] row_index(input logic [3:0] act);
    row_index = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (act[i]) row_index = 2'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Board-side matrix lines plus the decoded key outputs.
//               master = scanner side, slave = pins/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_n;
  logic [NUM_COLS-1:0] col_n;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_down;
  logic                multi_key;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, key_down, multi_key
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, key_down, multi_key
  );

endinterface
`default_nettype wire

// File: rtl/keypad_col_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_col_scan
// Description : Column rotation, row synchronizer and per-scan accumulation.
//               Emits a one-cycle scan_done with the NONE/SINGLE/MULTI result
//               of each full pass over the four columns.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 50000
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [NUM_ROWS-1:0] row_n,
  output logic      [NUM_COLS-1:0] col_n,
  output logic                     scan_done,
  output result_t                  res_type,
  output logic      [3:0]          res_code
);

  localparam int                  c_TICK_W    = $clog2(SCAN_TICKS);
  localparam logic [c_TICK_W-1:0] c_LAST_TICK = c_TICK_W'(SCAN_TICKS - 1);

  logic [NUM_ROWS-1:0] r_sync1;
  logic [NUM_ROWS-1:0] r_sync2;
  logic [c_TICK_W-1:0] r_tick;
  logic [1:0]          r_col;
  logic [1:0]          r_acc_cnt;   // keys seen so far, saturating at 2
  logic [3:0]          r_acc_code;
  logic                r_done;
  result_t             r_res_type;
  logic [3:0]          r_res_code;

  logic                w_last;
  logic [NUM_ROWS-1:0] w_act;
  logic [2:0]          w_pop;
  logic [2:0]          w_sum;
  logic [1:0]          w_new_cnt;
  logic [3:0]          w_new_code;

  assign w_last     = (r_tick == c_LAST_TICK);
  assign w_act      = ~r_sync2;
  assign w_pop      = count_active(w_act);
  assign w_sum      = {1'b0, r_acc_cnt} + w_pop;
  assign w_new_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  // Remember the code only when this column holds the first and only key.
  assign w_new_code = (r_acc_cnt == 2'd0 && w_pop == 3'd1) ?
                      {row_index(w_act), r_col} : r_acc_code;

  assign col_n     = ~((~COL_IDLE) << r_col);
  assign scan_done = r_done;
  assign res_type  = r_res_type;
  assign res_code  = r_res_code;

  // Two-flop synchronizer for the asynchronous row sense lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
    end
  end

  // Dwell counter per column and column rotation on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_col  <= 2'd0;
    end else if (w_last) begin
      r_tick <= '0;
      r_col  <= r_col + 2'd1;
    end else begin
      r_tick <= r_tick + c_TICK_W'(1);
    end
  end

  // Accumulate rows at the end of each column; publish the result after column 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
      r_done     <= 1'b0;
      r_res_type <= RES_NONE;
      r_res_code <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (w_last) begin
        if (r_col == 2'd3) begin
          r_done     <= 1'b1;
          r_res_type <= (w_new_cnt == 2'd0) ? RES_NONE :
                        (w_new_cnt == 2'd1) ? RES_SINGLE : RES_MULTI;
          r_res_code <= (w_new_cnt == 2'd1) ? w_new_code : 4'd0;
          r_acc_cnt  <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_cnt  <= w_new_cnt;
          r_acc_code <= w_new_code;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 active-low keypad scanner. Debounces full-scan results
//               and commits presses, rollovers and multi-key blocking.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS   = 50000,
  parameter int STABLE_SCANS = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  keypad_scanner_if.master  bus
);

  localparam int                 c_CNT_W  = $clog2(STABLE_SCANS + 1);
  localparam logic [c_CNT_W-1:0] c_STABLE = c_CNT_W'(STABLE_SCANS);

  logic               w_scan_done;
  result_t            w_res_type;
  logic [3:0]         w_res_code;

  result_t            r_prev_type;
  logic [3:0]         r_prev_code;
  logic [c_CNT_W-1:0] r_stable_cnt;
  logic               w_stable;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_key_code;
  logic [3:0]         w_code_nxt;
  logic               r_key_valid;
  logic               w_valid_nxt;

  keypad_col_scan #(
    .SCAN_TICKS (SCAN_TICKS)
  ) u_col_scan (
    .clk       (clk),
    .rst       (rst),
    .row_n     (bus.row_n),
    .col_n     (bus.col_n),
    .scan_done (w_scan_done),
    .res_type  (w_res_type),
    .res_code  (w_res_code)
  );

  // Count consecutive identical scan results, saturating at the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_type  <= RES_NONE;
      r_prev_code  <= 4'd0;
      r_stable_cnt <= '0;
    end else if (w_scan_done) begin
      r_prev_type <= w_res_type;
      r_prev_code <= w_res_code;
      if (w_res_type == r_prev_type && w_res_code == r_prev_code) begin
        if (r_stable_cnt != c_STABLE) r_stable_cnt <= r_stable_cnt + c_CNT_W'(1);
      end else begin
        r_stable_cnt <= c_CNT_W'(1);
      end
    end
  end

  assign w_stable = (r_stable_cnt == c_STABLE);

  // State, committed code and press strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
    end
  end

  // Act on the stable result; a stable result matching the state is a no-op.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    if (w_stable) begin
      unique case (r_state)
        IDLE, BLOCKED: begin
          if (r_prev_type == RES_SINGLE) begin
            w_state_nxt = PRESSED;
            w_code_nxt  = r_prev_code;
            w_valid_nxt = 1'b1;
          end else if (r_prev_type == RES_MULTI) begin
            w_state_nxt = BLOCKED;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        PRESSED: begin
          if (r_prev_type == RES_NONE) begin
            w_state_nxt = IDLE;
          end else if (r_prev_type == RES_MULTI) begin
            w_state_nxt = BLOCKED;
          end else if (r_prev_code != r_key_code) begin
            w_code_nxt  = r_prev_code;
            w_valid_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.key_code  = r_key_code;
  assign bus.key_valid = r_key_valid;
  assign bus.key_down  = (r_state == PRESSED);
  assign bus.multi_key = (r_state == BLOCKED);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed bench for keypad_scanner with a behavioural 4x4
//               key matrix (SCAN_TICKS=4, STABLE_SCANS=2, 16-cycle scan).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int c_SCAN = 16;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_down;
    logic        exp_multi;
  } step_t;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  row_v;
  int          cyc;
  int          pulse_total;
  int          passed;
  int          total;
  step_t       steps [10];

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_TICKS   (4),
    .STABLE_SCANS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a held key at (r,c) pulls row r low while column c is driven.
  always_comb begin
    row_v = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !bus.col_n[c]) row_v[r] = 1'b0;
      end
    end
  end
  assign bus.row_n = row_v;

  // Cycle index since reset release: cycle n has tick n%4, column (n/4)%4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (bus.key_valid) pulse_total <= pulse_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    while (cyc % c_SCAN != 0) @(negedge clk);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, " col_n"},     32'(bus.col_n),     32'(4'b1110));
    check({tag, " key_code"},  32'(bus.key_code),  32'd0);
    check({tag, " key_valid"}, 32'(bus.key_valid), 32'd0);
    check({tag, " key_down"},  32'(bus.key_down),  32'd0);
    check({tag, " multi_key"}, 32'(bus.multi_key), 32'd0);
  endtask

  task automatic run_step(input int i);
    int p0;
    align();
    p0   = pulse_total;
    keys = steps[i].keys;
    advance(c_SCAN * steps[i].scans);
    check($sformatf("step%0d pulses", i),    32'(pulse_total - p0),  32'(steps[i].exp_pulses));
    check($sformatf("step%0d key_code", i),  32'(bus.key_code),      32'(steps[i].exp_code));
    check($sformatf("step%0d key_down", i),  32'(bus.key_down),      32'(steps[i].exp_down));
    check($sformatf("step%0d multi_key", i), 32'(bus.multi_key),     32'(steps[i].exp_multi));
  endtask

  initial begin
    int         p0;
    logic [3:0] exp_col;

    passed      = 0;
    total       = 0;
    pulse_total = 0;
    keys        = 16'h0000;
    rst         = 1'b1;

    //           keys                       scans pulses code down multi
    steps[0] = '{16'h0040,                  10,   1,     4'd6,  1'b1, 1'b0};
    steps[1] = '{16'h0000,                  4,    0,     4'd6,  1'b0, 1'b0};
    steps[2] = '{16'h0000,                  3,    0,     4'd9,  1'b0, 1'b0};
    steps[3] = '{16'h8000,                  4,    1,     4'd15, 1'b1, 1'b0};
    steps[4] = '{16'h0400,                  4,    1,     4'd10, 1'b1, 1'b0};
    steps[5] = '{16'h0000,                  4,    0,     4'd10, 1'b0, 1'b0};
    steps[6] = '{16'h0021,                  5,    0,     4'd10, 1'b0, 1'b1};
    steps[7] = '{16'h0020,                  5,    1,     4'd5,  1'b1, 1'b0};
    steps[8] = '{16'h0021,                  4,    0,     4'd5,  1'b0, 1'b1};
    steps[9] = '{16'h0000,                  4,    0,     4'd5,  1'b0, 1'b0};

    // Reset state, then column rotation every 4 cycles, period 16.
    advance(2);
    check_outputs_clear("in_reset");
    rst = 1'b0;
    check_outputs_clear("post_reset");
    for (int k = 1; k <= 4; k++) begin
      advance(4);
      exp_col = 4'b1111;
      exp_col[k % 4] = 1'b0;
      check($sformatf("col_n at cycle %0d", 4 * k), 32'(bus.col_n), 32'(exp_col));
    end

    // Single press and release.
    run_step(0);
    run_step(1);

    // Bounce on code 9 (row2 col1) every 5 cycles for 3 scans, then steady.
    align();
    p0 = pulse_total;
    for (int r = 0; r < 48; r++) begin
      keys = ((r / 5) % 2 == 0) ? 16'h0200 : 16'h0000;
      advance(1);
    end
    check("bounce pulses",   32'(pulse_total - p0), 32'd0);
    check("bounce key_down", 32'(bus.key_down),     32'd0);
    keys = 16'h0200;
    advance(4 * c_SCAN);
    check("settle pulses",   32'(pulse_total - p0), 32'd1);
    check("settle key_code", 32'(bus.key_code),     32'd9);
    check("settle key_down", 32'(bus.key_down),     32'd1);

    // Release, new key, rollover, multi-key from idle and from pressed.
    for (int i = 2; i < 10; i++) run_step(i);

    // Asynchronous reset while code 3 is held.
    align();
    p0   = pulse_total;
    keys = 16'h0008;
    advance(4 * c_SCAN);
    check("hold3 pulses",   32'(pulse_total - p0), 32'd1);
    check("hold3 key_code", 32'(bus.key_code),     32'd3);
    advance(6);
    rst = 1'b1;
    #1;
    check_outputs_clear("async_rst");
    @(negedge clk);
    rst = 1'b0;
    p0  = pulse_total;
    advance(4 * c_SCAN);
    check("rehold pulses",   32'(pulse_total - p0), 32'd1);
    check("rehold key_code", 32'(bus.key_code),     32'd3);
    check("rehold key_down", 32'(bus.key_down),     32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low key matrix and encodes a debounced key press into a 4-bit code with a one-cycle press strobe.
- Input-side counterpart to the seven-segment display path: the display path decodes a digit to segment drive; this block turns matrix lines back into a digit/code for the counter and display logic.
- Sits between the board pins (column drive, row sense) and the digit-consuming logic.

Parameters:
- SCAN_TICKS, 50000, clk cycles each column is driven (legal minimum 4).
- STABLE_SCANS, 4, consecutive identical full-scan results needed to commit a press or release (legal minimum 1).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- row_n  in  4  matrix row sense, active-low (pulled up), asynchronous to clk
- col_n  out  4  matrix column drive, active-low, exactly one bit low
- key_code  out  4  last committed key, {row[1:0], col[1:0]}
- key_valid  out  1  one-cycle pulse when a new key is committed
- key_down  out  1  level, high while a committed key is held
- multi_key  out  1  level, high while a stable multi-key result is present

Behaviour:
- Reset values (async, immediate): col_n=4'b1110, key_code=0, key_valid=0, key_down=0, multi_key=0. FSM goes to IDLE, tick/column/stable counters go to 0, scan accumulator is cleared, and both synchronizer stages go to 4'b1111.
- row_n passes through a 2-flop synchronizer before any use.
- Column scan:
  - Tick counter runs 0..SCAN_TICKS-1 and wraps.
  - On wrap, the column index advances 0->1->2->3->0. col_n = ~(1<<col).
  - The synchronized row value is sampled on tick SCAN_TICKS-1 of each column, which leaves at least 2 cycles of settle plus sync delay.
- Scan result, registered on the tick SCAN_TICKS-1 of column 3:
  - NONE if 0 keys were seen across the 4 columns.
  - SINGLE(code) if exactly 1 key was seen.
  - MULTI if 2 or more keys were seen.
  - The accumulator clears for the next scan.
- Stability:
  - A result equal to the previous result (type and code) increments a saturating stable counter. Otherwise the counter resets to 1.
  - A result is "stable" when the counter reaches STABLE_SCANS. The counter width is $clog2(STABLE_SCANS+1).
- FSM states:
  - IDLE: key_down=0. A stable SINGLE(c) sets key_code=c and pulses key_valid on the next cycle, then goes to PRESSED. A stable MULTI sets multi_key=1 and goes to BLOCKED.
  - PRESSED: key_down=1.
    - Stable NONE -> IDLE, key_down=0.
    - Stable SINGLE(c') with c' != key_code -> rollover: key_code=c', key_valid pulse, stay in PRESSED.
    - Stable MULTI -> BLOCKED, key_down=0, multi_key=1. key_code is held.
  - BLOCKED: no key_valid ever. Stable NONE -> IDLE, multi_key=0. Stable SINGLE -> treated as a fresh press (as from IDLE), multi_key=0.
- A stable result re-asserting the current state causes no action. key_valid never pulses twice for one committed press.
- key_code holds its value after release until the next commit.
- Latency: press-to-key_valid is at most (STABLE_SCANS+1)*4*SCAN_TICKS+3 cycles from the row edge.
- Reset mid-operation aborts everything. A key still held afterward is re-debounced from scratch and produces a new pulse.

Decomposition:
- keypad_pkg:
  - FSM state enum (IDLE, PRESSED, BLOCKED).
  - Scan-result type enum (NONE, SINGLE, MULTI).
  - Constants NUM_ROWS=4, NUM_COLS=4, COL_IDLE=4'b1110.
- Sub-module keypad_col_scan: tick counter, column rotation, synchronizer, per-scan accumulation. Outputs a scan-done strobe plus result type/code. The stability counter and FSM stay in keypad_scanner.

Test Plan (SCAN_TICKS=4, STABLE_SCANS=2, so a scan is 16 cycles):
- Reset: assert rst, release. Required: col_n=1110, all outputs 0; col_n=1101 after 4 cycles; pattern repeats every 16 cycles.
- Single press: row1 col2 (code 6), held 10 scans. Required: exactly one key_valid pulse with key_code=6, within 2-3 scans; key_down=1 for the duration.
- Bounce: row_n toggles every 5 cycles for 3 scans, then stable on code 9. Required: no key_valid during the bounce, then one pulse with key_code=9.
- Release and new key: release code 9, key_down=0 after 2 empty scans, then press code 15. Required: one pulse with key_code=15.
- Multi-key and rollover: codes 0 and 5 together. Required: multi_key=1, no pulse, key_code unchanged. Then release 0 only. Required: multi_key=0, pulse with key_code=5.
- Async rst asserted mid-PRESSED (code 3 held). Required: outputs clear and col_n=1110 immediately (same cycle). After release of rst with code 3 still held: fresh key_valid with key_code=3.
